// File: rtl/iterative_shift_ctrl.sv
// Iterative 1-bit-per-cycle shifter (SLL/SRL/SRA/ROR); latency shamt+1 cycles (1 for shamt=0).
// No backpressure: start is accepted only when not busy, requests during SHIFT are dropped.
module iterative_shift_ctrl #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [1:0]     OP_SLL  = 2'b00;
    localparam logic [1:0]     OP_SRL  = 2'b01;
    localparam logic [1:0]     OP_SRA  = 2'b10;
    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_step;
    logic [SHW-1:0]   cnt;
    logic [1:0]       op_q;
    logic             accept;
    logic             last_step;

    assign accept    = start && (state != SHIFT);
    assign last_step = (state == SHIFT) && (cnt == CNT_ONE);
    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);

    always_comb begin
        acc_step = acc;
        case (op_q)
            OP_SLL:  acc_step = {acc[WIDTH-2:0], 1'b0};
            OP_SRL:  acc_step = {1'b0, acc[WIDTH-1:1]};
            OP_SRA:  acc_step = {acc[WIDTH-1], acc[WIDTH-1:1]};
            default: acc_step = {acc[0], acc[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = (shamt == '0) ? DONE : SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (cnt == CNT_ONE) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // result is only written on entry to DONE so partial shifts never leak out
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            cnt    <= '0;
            op_q   <= '0;
            result <= '0;
        end else if (accept) begin
            acc  <= data_in;
            cnt  <= shamt;
            op_q <= op;
            if (shamt == '0) begin
                result <= data_in;
            end
        end else if (state == SHIFT) begin
            acc <= acc_step;
            cnt <= cnt - CNT_ONE;
            if (last_step) begin
                result <= acc_step;
            end
        end
    end

endmodule

// File: tb/tb_iterative_shift_ctrl.sv
// Scoreboard bench for iterative_shift_ctrl: stimulus pushes expected result/timing, a negedge monitor checks each done.
module tb_iterative_shift_ctrl;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    typedef struct {
        logic [31:0] res;
        int          done_cyc;
        int          nbusy;
        int          tag;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] data_in = '0;
    logic [4:0]  shamt = '0;
    logic [31:0] result;
    logic        busy;
    logic        done;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   busy_run = 0;
    int   issued = 0;
    int   dones_seen = 0;

    iterative_shift_ctrl #(.WIDTH(32), .SHW(5)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .data_in (data_in),
        .shamt   (shamt),
        .result  (result),
        .busy    (busy),
        .done    (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // Monitor: pops one expectation per done and checks value, latency and busy span
    always @(negedge clock) begin
        if (reset) begin
            busy_run = 0;
        end else begin
            if (busy && done) begin
                errors++;
                $display("FAIL busy_done_overlap cyc=%0d busy=%b done=%b required not both high", cyc, busy, done);
            end
            if (busy) busy_run++;
            if (done) begin
                exp_t e;
                dones_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done cyc=%0d result=%h required no done", cyc, result);
                end else begin
                    e = exp_q.pop_front();
                    checks += 2;
                    if (result !== e.res) begin
                        errors++;
                        $display("FAIL result_tag%0d got=%h required=%h", e.tag, result, e.res);
                    end
                    if (cyc != e.done_cyc) begin
                        errors++;
                        $display("FAIL latency_tag%0d done_cyc=%0d required=%0d", e.tag, cyc, e.done_cyc);
                    end
                    if (busy_run != e.nbusy) begin
                        errors++;
                        $display("FAIL busy_cycles_tag%0d got=%0d required=%0d", e.tag, busy_run, e.nbusy);
                    end
                end
                busy_run = 0;
            end
        end
    end

    // Called in the post-edge phase; start is sampled at the next rising edge
    task automatic issue(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
                         input logic [31:0] res, input int tag);
        exp_t e;
        e.res      = res;
        e.done_cyc = cyc + 1 + int'(s);
        e.nbusy    = int'(s);
        e.tag      = tag;
        exp_q.push_back(e);
        issued++;
        start   = 1'b1;
        op      = o;
        data_in = d;
        shamt   = s;
        @(posedge clock); #1;
        start   = 1'b0;
        data_in = $urandom;
        shamt   = 5'($urandom);
        op      = 2'($urandom);
    endtask

    task automatic wait_done(input int budget, input int tag);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(posedge clock); #1;
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout_tag%0d waited=%0d cycles done=%b required=1", tag, n, done);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic check_outputs(input string name, input logic [31:0] r, input logic b, input logic d);
        checks++;
        if (result !== r || busy !== b || done !== d) begin
            errors++;
            $display("FAIL %s result=%h busy=%b done=%b required result=%h busy=%b done=%b",
                     name, result, busy, done, r, b, d);
        end
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check_outputs("reset_state", 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        idle_cycles(2);

        // Basic shifts
        issue(SRA, 32'h8000_0000, 5'd4, 32'hF800_0000, 1);
        wait_done(40, 1); idle_cycles(1);
        issue(SRL, 32'h8000_0000, 5'd4, 32'h0800_0000, 2);
        wait_done(40, 2); idle_cycles(1);
        issue(SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 3);
        wait_done(40, 3); idle_cycles(1);
        issue(SLL, 32'hDEAD_BEEF, 5'd4, 32'hEADB_EEF0, 4);
        wait_done(40, 4); idle_cycles(1);
        issue(ROR, 32'h1234_5678, 5'd8, 32'h7812_3456, 5);
        wait_done(40, 5); idle_cycles(1);
        issue(SRA, 32'hF000_0000, 5'd31, 32'hFFFF_FFFF, 6);
        wait_done(40, 6); idle_cycles(1);
        issue(SRA, 32'h4000_0000, 5'd31, 32'h0000_0000, 7);
        wait_done(40, 7); idle_cycles(1);

        // Zero shift amount for every op
        for (int i = 0; i < 4; i++) begin
            issue(2'(i), 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 10 + i);
            wait_done(5, 10 + i); idle_cycles(1);
        end

        // Back-to-back issue in the done cycle
        issue(ROR, 32'h0000_0003, 5'd1, 32'h8000_0001, 20);
        wait_done(10, 20);
        issue(SRA, 32'h7FFF_FFFF, 5'd2, 32'h1FFF_FFFF, 21);
        wait_done(10, 21);
        issue(SLL, 32'h0000_00FF, 5'd0, 32'h0000_00FF, 22);
        wait_done(5, 22); idle_cycles(1);

        // Start pulsed mid-SHIFT must be dropped
        issue(SRL, 32'h8000_0000, 5'd4, 32'h0800_0000, 30);
        idle_cycles(1);
        start = 1'b1; op = SLL; data_in = 32'hFFFF_FFFF; shamt = 5'd1;
        idle_cycles(1);
        start = 1'b0;
        wait_done(40, 30);
        idle_cycles(6);
        check_outputs("result_hold_idle", 32'h0800_0000, 1'b0, 1'b0);

        // Reset in the middle of a shift
        issue(SLL, 32'h0000_0001, 5'd20, 32'h0010_0000, 40);
        idle_cycles(7);
        check_outputs("busy_before_reset", 32'h0800_0000, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        check_outputs("async_reset_clears", 32'h0, 1'b0, 1'b0);
        exp_q.delete();
        issued--;
        idle_cycles(2);
        reset = 1'b0;
        idle_cycles(25);
        check_outputs("no_done_after_reset", 32'h0, 1'b0, 1'b0);
        issue(SLL, 32'h0000_0001, 5'd20, 32'h0010_0000, 41);
        wait_done(40, 41); idle_cycles(2);

        checks++;
        if (exp_q.size() != 0 || dones_seen != issued) begin
            errors++;
            $display("FAIL done_count dones=%0d pending=%0d required dones=%0d pending=0",
                     dones_seen, exp_q.size(), issued);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d required finish before timeout", cyc);
        $fatal(1, "timeout");
    end

endmodule
